// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for one memory port; optional ARB_FIXED_PRIORITY_EN
module mem_port_arbiter #(
  parameter int N        = 32,
  parameter int HOLD_MAX = 8
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         m0_req,
  input  logic         m0_wr_ena,
  input  logic [N-1:0] m0_addr,
  input  logic [N-1:0] m0_wr_data,
  output logic         m0_gnt,
  output logic         m0_rd_valid,
  output logic [N-1:0] m0_rd_data,
  input  logic         m1_req,
  input  logic         m1_wr_ena,
  input  logic [N-1:0] m1_addr,
  input  logic [N-1:0] m1_wr_data,
  output logic         m1_gnt,
  output logic         m1_rd_valid,
  output logic [N-1:0] m1_rd_data,
  output logic         mem_wr_ena,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wr_data,
  input  logic [N-1:0] mem_rd_data
);

  localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  logic [1:0]    owner, owner_nxt;
  logic          last_winner, last_winner_nxt;
  logic [HW-1:0] hold_cnt, hold_cnt_nxt;
  logic          rd_valid0, rd_valid1;
  logic          cur_req, oth_req, oth_id, preempt_ok;
  logic          enter, enter_sel;

  assign m0_gnt      = (owner == ST_OWN0) & m0_req;
  assign m1_gnt      = (owner == ST_OWN1) & m1_req;
  assign m0_rd_valid = rd_valid0;
  assign m1_rd_valid = rd_valid1;
  assign m0_rd_data  = mem_rd_data;
  assign m1_rd_data  = mem_rd_data;

  // Memory port carries the granted requester's fields, otherwise parks at zero
  always_comb begin
    mem_wr_ena  = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (m0_gnt) begin
      mem_wr_ena  = m0_wr_ena;
      mem_addr    = m0_addr;
      mem_wr_data = m0_wr_data;
    end else if (m1_gnt) begin
      mem_wr_ena  = m1_wr_ena;
      mem_addr    = m1_addr;
      mem_wr_data = m1_wr_data;
    end
  end

  // Ownership decision: handoff on release, HOLD_MAX preemption, tie-break from idle
  always_comb begin
    owner_nxt       = owner;
    last_winner_nxt = last_winner;
    hold_cnt_nxt    = hold_cnt;
    enter           = 1'b0;
    enter_sel       = 1'b0;
    cur_req         = (owner == ST_OWN1) ? m1_req : m0_req;
    oth_req         = (owner == ST_OWN1) ? m0_req : m1_req;
    oth_id          = (owner == ST_OWN0);
`ifdef ARB_FIXED_PRIORITY_EN
    // M0 keeps the port as long as it asks; only M1 tenure is bounded
    preempt_ok      = (owner == ST_OWN1);
`else
    preempt_ok      = 1'b1;
`endif
    case (owner)
      ST_OWN0, ST_OWN1: begin
        if (!cur_req) begin
          if (oth_req) begin
            enter     = 1'b1;
            enter_sel = oth_id;
          end else begin
            owner_nxt = ST_IDLE;
          end
        end else if (oth_req && preempt_ok && (hold_cnt == HOLD_LAST)) begin
          enter     = 1'b1;
          enter_sel = oth_id;
        end else if (oth_req) begin
          if (hold_cnt != HOLD_LAST) hold_cnt_nxt = hold_cnt + 1'b1;
        end else begin
          hold_cnt_nxt = '0;
        end
      end
      default: begin
        if (m0_req && m1_req) begin
          enter     = 1'b1;
`ifdef ARB_FIXED_PRIORITY_EN
          enter_sel = 1'b0;
`else
          enter_sel = ~last_winner;
`endif
        end else if (m0_req) begin
          enter     = 1'b1;
          enter_sel = 1'b0;
        end else if (m1_req) begin
          enter     = 1'b1;
          enter_sel = 1'b1;
        end
      end
    endcase
    if (enter) begin
      owner_nxt       = enter_sel ? ST_OWN1 : ST_OWN0;
      last_winner_nxt = enter_sel;
      hold_cnt_nxt    = '0;
    end
  end

  // Arbitration state; last_winner starts at M1 so M0 wins the first tie
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      owner       <= ST_IDLE;
      last_winner <= 1'b1;
      hold_cnt    <= '0;
    end else begin
      owner       <= owner_nxt;
      last_winner <= last_winner_nxt;
      hold_cnt    <= hold_cnt_nxt;
    end
  end

  // Read-valid tracks granted reads one cycle later; reset drops anything in flight
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rd_valid0 <= 1'b0;
      rd_valid1 <= 1'b0;
    end else begin
      rd_valid0 <= m0_gnt & ~m0_wr_ena;
      rd_valid1 <= m1_gnt & ~m1_wr_ena;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int N    = 32;
  localparam int HOLD = 4;

  logic         clk = 1'b0;
  logic         rstb;
  logic         m0_req, m0_wr_ena, m0_gnt, m0_rd_valid;
  logic [N-1:0] m0_addr, m0_wr_data, m0_rd_data;
  logic         m1_req, m1_wr_ena, m1_gnt, m1_rd_valid;
  logic [N-1:0] m1_addr, m1_wr_data, m1_rd_data;
  logic         mem_wr_ena;
  logic [N-1:0] mem_addr, mem_wr_data, mem_rd_data;

  mem_port_arbiter #(.N(N), .HOLD_MAX(HOLD)) dut (
    .clk(clk), .rstb(rstb),
    .m0_req(m0_req), .m0_wr_ena(m0_wr_ena), .m0_addr(m0_addr), .m0_wr_data(m0_wr_data),
    .m0_gnt(m0_gnt), .m0_rd_valid(m0_rd_valid), .m0_rd_data(m0_rd_data),
    .m1_req(m1_req), .m1_wr_ena(m1_wr_ena), .m1_addr(m1_addr), .m1_wr_data(m1_wr_data),
    .m1_gnt(m1_gnt), .m1_rd_valid(m1_rd_valid), .m1_rd_data(m1_rd_data),
    .mem_wr_ena(mem_wr_ena), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory with one cycle read latency
  logic [N-1:0] ram [64];
  always @(posedge clk) begin
    mem_rd_data <= ram[mem_addr[5:0]];
    if (mem_wr_ena) ram[mem_addr[5:0]] <= mem_wr_data;
  end

  // Requester intentions and reference model state
  bit           rq [2];
  bit           wr [2];
  logic [N-1:0] ad [2];
  logic [N-1:0] wd [2];
  bit           eg [2];
  bit           pv [2];
  logic [N-1:0] pd [2];
  logic [N-1:0] shadow [64];
  int           own;
  int           last;
  int           run;
  bit           rst_drv;
  int           checks = 0;
  int           errors = 0;
  bit           done;
  logic [1:0]   code, exp_code;

  function automatic logic [N-1:0] init_val(input int i);
    return 32'h1000_0000 + i * 32'h0000_0101;
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    own   = -1;
    last  = 1;
    run   = 0;
    pv[0] = 0;
    pv[1] = 0;
  endtask

  task automatic take(input int w);
    own  = w;
    last = w;
    run  = 0;
  endtask

  // Reference: owner decides, requests checked against the tenure rules
  task automatic advance();
    int x, y, w;
    for (int i = 0; i < 2; i++) begin
      pv[i] = eg[i] && !wr[i];
      if (pv[i]) pd[i] = shadow[ad[i][5:0]];
      if (eg[i] && wr[i]) shadow[ad[i][5:0]] = wd[i];
    end
    if (own < 0) begin
`ifdef ARB_FIXED_PRIORITY_EN
      w = 0;
`else
      w = 1 - last;
`endif
      if (rq[0] && rq[1]) take(w);
      else if (rq[0]) take(0);
      else if (rq[1]) take(1);
    end else begin
      x = own;
      y = 1 - own;
      if (!rq[x]) begin
        if (rq[y]) take(y);
        else own = -1;
      end else if (rq[y]) begin
        run++;
`ifdef ARB_FIXED_PRIORITY_EN
        if (run >= HOLD && x == 1) take(y);
`else
        if (run >= HOLD) take(y);
`endif
      end else begin
        run = 0;
      end
    end
  endtask

  // One clock: drive at negedge, compare 1ns later, then step the model
  task automatic tick();
    bit           ewe;
    logic [N-1:0] ea, ewd;
    @(negedge clk);
    rstb       = rst_drv;
    m0_req     = rq[0]; m0_wr_ena = wr[0]; m0_addr = ad[0]; m0_wr_data = wd[0];
    m1_req     = rq[1]; m1_wr_ena = wr[1]; m1_addr = ad[1]; m1_wr_data = wd[1];
    if (!rst_drv) model_reset();
    #1;
    ewe = 0; ea = '0; ewd = '0;
    for (int i = 0; i < 2; i++) begin
      eg[i] = (own == i) && rq[i];
      if (eg[i]) begin
        ewe = wr[i];
        ea  = ad[i];
        ewd = wd[i];
      end
    end
    chk("m0_gnt", {31'd0, m0_gnt}, {31'd0, eg[0]});
    chk("m1_gnt", {31'd0, m1_gnt}, {31'd0, eg[1]});
    chk("mem_wr_ena", {31'd0, mem_wr_ena}, {31'd0, ewe});
    chk("mem_addr", mem_addr, ea);
    chk("mem_wr_data", mem_wr_data, ewd);
    chk("m0_rd_valid", {31'd0, m0_rd_valid}, {31'd0, pv[0]});
    chk("m1_rd_valid", {31'd0, m1_rd_valid}, {31'd0, pv[1]});
    if (pv[0]) chk("m0_rd_data", m0_rd_data, pd[0]);
    if (pv[1]) chk("m1_rd_data", m1_rd_data, pd[1]);
    if (rst_drv) advance();
  endtask

  task automatic set_req(input int x, input bit w, input logic [N-1:0] a, input logic [N-1:0] d);
    rq[x] = 1; wr[x] = w; ad[x] = a; wd[x] = d;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram[i]    = init_val(i);
      shadow[i] = init_val(i);
    end
    rstb = 1'b1;
    m0_req = 0; m0_wr_ena = 0; m0_addr = '0; m0_wr_data = '0;
    m1_req = 0; m1_wr_ena = 0; m1_addr = '0; m1_wr_data = '0;
    for (int i = 0; i < 2; i++) begin
      rq[i] = 0; wr[i] = 0; ad[i] = '0; wd[i] = '0; eg[i] = 0; pd[i] = '0;
    end
    model_reset();

    // Reset with both requesting: everything quiet
    set_req(0, 0, 32'h3, 32'h0);
    set_req(1, 1, 32'h4, 32'h55);
    rst_drv = 0;
    tick();
    tick();
    chk("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    chk("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    chk("rst_mem_wr_ena", {31'd0, mem_wr_ena}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_rd_valids", {30'd0, m1_rd_valid, m0_rd_valid}, 32'd0);
    rq[0] = 0; rq[1] = 0;
    rst_drv = 1;
    tick();

    // M0 read of 0x10 from idle
    set_req(0, 0, 32'h10, 32'h0);
    tick();
    chk("t2_no_gnt_first", {31'd0, m0_gnt}, 32'd0);
    tick();
    chk("t2_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("t2_addr", mem_addr, 32'h10);
    rq[0] = 0;
    tick();
    chk("t2_rd_valid", {31'd0, m0_rd_valid}, 32'd1);
    chk("t2_rd_data", m0_rd_data, init_val(16));
    chk("t2_m1_rd_valid", {31'd0, m1_rd_valid}, 32'd0);

    // M1 write then read back
    set_req(1, 1, 32'h8, 32'hDEADBEEF);
    done = 0;
    for (int k = 0; k < 4 && !done; k++) begin
      tick();
      if (eg[1]) begin
        chk("t3_wr_ena", {31'd0, mem_wr_ena}, 32'd1);
        chk("t3_wr_data", mem_wr_data, 32'hDEADBEEF);
        done = 1;
      end
    end
    chk("t3_wr_granted", {31'd0, done}, 32'd1);
    set_req(1, 0, 32'h8, 32'h0);
    done = 0;
    for (int k = 0; k < 4 && !done; k++) begin
      tick();
      if (eg[1]) done = 1;
    end
    chk("t3_rd_granted", {31'd0, done}, 32'd1);
    rq[1] = 0;
    tick();
    chk("t3_rd_valid", {31'd0, m1_rd_valid}, 32'd1);
    chk("t3_rd_data", m1_rd_data, 32'hDEADBEEF);

    // Continuous contention from a fresh reset: alternating tenures of HOLD grants
    rst_drv = 0;
    tick();
    rst_drv = 1;
    set_req(0, 0, 32'h21, 32'h0);
    set_req(1, 0, 32'h22, 32'h0);
    for (int k = 0; k <= 10; k++) begin
      tick();
      code = {m1_gnt, m0_gnt};
      if (k == 0) exp_code = 2'b00;
`ifdef ARB_FIXED_PRIORITY_EN
      else exp_code = 2'b01;
`else
      else exp_code = (((k - 1) / HOLD) % 2 == 0) ? 2'b01 : 2'b10;
`endif
      chk($sformatf("t4_grant_seq_%0d", k), {30'd0, code}, {30'd0, exp_code});
    end

    // M0 releases while M1 waits: M1 takes over next cycle
    rq[0] = 0;
    tick();
    chk("t5_release_m0_gnt", {31'd0, m0_gnt}, 32'd0);
    tick();
    chk("t5_handoff_m1_gnt", {31'd0, m1_gnt}, 32'd1);
    rq[1] = 0;
    tick();

    // Reset between grant and rd_valid drops the read
    set_req(0, 0, 32'h5, 32'h0);
    done = 0;
    for (int k = 0; k < 4 && !done; k++) begin
      tick();
      if (eg[0]) done = 1;
    end
    chk("t6_granted", {31'd0, done}, 32'd1);
    rq[0] = 0;
    rst_drv = 0;
    tick();
    chk("t6_rd_valid_in_rst", {31'd0, m0_rd_valid}, 32'd0);
    rst_drv = 1;
    tick();
    chk("t6_rd_valid_after", {31'd0, m0_rd_valid}, 32'd0);

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (eg[i]) rq[i] = 0;
        if (!rq[i] && $urandom_range(0, 3) != 0)
          set_req(i, 1'($urandom_range(0, 1)), N'($urandom_range(0, 63)), N'($urandom));
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
